// File: rtl/swt16_pkg.sv
// swt16_pkg: constants and result record shared by the swt16 execute,
// writeback and register-file stages.
//   WORD_WIDTH  - datapath width
//   IDX_WIDTH   - register index width
//   NUM_REGS    - register count (2**IDX_WIDTH)
//   wb_result_t - {valid, idx, data} result carried toward the register file
package swt16_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int IDX_WIDTH  = 4;
  localparam int NUM_REGS   = 1 << IDX_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [IDX_WIDTH-1:0]  idx;
    logic [WORD_WIDTH-1:0] data;
  } wb_result_t;
endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: issue, ALU, long-unit and register-file signals of the
// writeback stage.
//   slave  - the writeback stage (consumes issue/results, drives stall,
//            lu_ready, the write port and the busy scoreboard)
//   master - the surrounding pipeline
interface writeback_stage_if;
  import swt16_pkg::*;

  logic                  iss_valid;
  logic [IDX_WIDTH-1:0]  iss_src1_idx;
  logic [IDX_WIDTH-1:0]  iss_src2_idx;
  logic [IDX_WIDTH-1:0]  iss_dst_idx;
  logic                  iss_has_dst;
  logic                  iss_stall;

  logic                  alu_valid;
  logic [IDX_WIDTH-1:0]  alu_dst_idx;
  logic [WORD_WIDTH-1:0] alu_data;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [IDX_WIDTH-1:0]  lu_dst_idx;
  logic [WORD_WIDTH-1:0] lu_data;

  logic                  rf_write;
  logic [IDX_WIDTH-1:0]  rf_dst_idx;
  logic [WORD_WIDTH-1:0] rf_dst;

  logic [NUM_REGS-1:0]   busy;

  modport slave (
    input  iss_valid, iss_src1_idx, iss_src2_idx, iss_dst_idx, iss_has_dst,
    output iss_stall,
    input  alu_valid, alu_dst_idx, alu_data,
    input  lu_valid, lu_dst_idx, lu_data,
    output lu_ready,
    output rf_write, rf_dst_idx, rf_dst,
    output busy
  );

  modport master (
    output iss_valid, iss_src1_idx, iss_src2_idx, iss_dst_idx, iss_has_dst,
    input  iss_stall,
    output alu_valid, alu_dst_idx, alu_data,
    output lu_valid, lu_dst_idx, lu_data,
    input  lu_ready,
    input  rf_write, rf_dst_idx, rf_dst,
    input  busy
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write bits.
//   set_en/set_idx  - mark a register busy (issue accepted with a destination)
//   clr_en/clr_idx  - retire a register (write port fired last cycle)
//   src1/src2/dst   - operands of the instruction being presented
//   hazard          - RAW on either source or WAW on the destination
//   busy            - current scoreboard; bit 0 is always 0
module wb_scoreboard
  import swt16_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [IDX_WIDTH-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [IDX_WIDTH-1:0] clr_idx,
  input  logic [IDX_WIDTH-1:0] src1_idx,
  input  logic [IDX_WIDTH-1:0] src2_idx,
  input  logic [IDX_WIDTH-1:0] dst_idx,
  input  logic                 has_dst,
  output logic                 hazard,
  output logic [NUM_REGS-1:0]  busy
);
  logic [NUM_REGS-1:0] busy_q, busy_nxt;

  // Clear is applied before set so a same-index collision leaves the bit set:
  // the new writer still owns the register after the old value lands.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy   = busy_q;
  assign hazard = busy_q[src1_idx] || busy_q[src2_idx] ||
                  (has_dst && busy_q[dst_idx]);
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: merges single-cycle ALU results with long-unit results
// into one registered register-file write port and tracks pending writes.
//   clock, reset - rising-edge clock, async active-low reset
//   wb (slave)   - issue check/stall, ALU result, long-unit valid/ready,
//                  rf write port, busy scoreboard
// ALU results always win the port; a long-unit result waits in a one-entry
// hold. An age counter bounds how long the hold can be bypassed: at MAX_WAIT
// issue stalls so the ALU pipe drains and the hold gets the port.
module writeback_stage
  import swt16_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  writeback_stage_if.slave  wb
);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  wb_result_t            hold_q, sel_res;
  logic [AGE_W-1:0]      age_q;
  logic                  lu_ready, lu_xfer, wr_en, age_stall, hazard;
  logic                  set_en, iss_stall;
  logic                  rf_write_q;
  logic [IDX_WIDTH-1:0]  rf_dst_idx_q;
  logic [WORD_WIDTH-1:0] rf_dst_q;

  // A hold being drained this cycle (no ALU result) may be refilled at once.
  assign lu_ready = !hold_q.valid || !wb.alu_valid;
  assign lu_xfer  = wb.lu_valid && lu_ready;

  always_comb begin
    sel_res = '0;
    if (wb.alu_valid) begin
      sel_res.valid = 1'b1;
      sel_res.idx   = wb.alu_dst_idx;
      sel_res.data  = wb.alu_data;
    end else if (hold_q.valid) begin
      sel_res = hold_q;
    end
  end

  // r0 results consume their slot (and drain the hold) but never write.
  assign wr_en = sel_res.valid && (sel_res.idx != '0);

  assign age_stall = hold_q.valid && (age_q == AGE_W'(MAX_WAIT));
  assign iss_stall = wb.iss_valid && (hazard || age_stall);
  assign set_en    = wb.iss_valid && !iss_stall && wb.iss_has_dst &&
                     (wb.iss_dst_idx != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      age_q  <= '0;
    end else begin
      if (lu_xfer) begin
        hold_q.valid <= 1'b1;
        hold_q.idx   <= wb.lu_dst_idx;
        hold_q.data  <= wb.lu_data;
      end else if (!wb.alu_valid) begin
        hold_q.valid <= 1'b0;
      end
      if (lu_xfer)
        age_q <= '0;
      else if (hold_q.valid && wb.alu_valid && (age_q != AGE_W'(MAX_WAIT)))
        age_q <= age_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_write_q   <= 1'b0;
      rf_dst_idx_q <= '0;
      rf_dst_q     <= '0;
    end else begin
      rf_write_q <= wr_en;
      if (wr_en) begin
        rf_dst_idx_q <= sel_res.idx;
        rf_dst_q     <= sel_res.data;
      end
    end
  end

  // Busy clears on the edge where the register file captures the write.
  wb_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (set_en),
    .set_idx  (wb.iss_dst_idx),
    .clr_en   (rf_write_q),
    .clr_idx  (rf_dst_idx_q),
    .src1_idx (wb.iss_src1_idx),
    .src2_idx (wb.iss_src2_idx),
    .dst_idx  (wb.iss_dst_idx),
    .has_dst  (wb.iss_has_dst),
    .hazard   (hazard),
    .busy     (wb.busy)
  );

  assign wb.iss_stall  = iss_stall;
  assign wb.lu_ready   = lu_ready;
  assign wb.rf_write   = rf_write_q;
  assign wb.rf_dst_idx = rf_dst_idx_q;
  assign wb.rf_dst     = rf_dst_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios with a queue of expected register
// file writes; a negedge monitor pops and compares every write.
module tb_writeback_stage;
  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  writeback_stage_if wb();

  writeback_stage #(.MAX_WAIT(3)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic [15:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input logic v, input logic [3:0] idx, input logic [15:0] data);
    wb.alu_valid   = v;
    wb.alu_dst_idx = idx;
    wb.alu_data    = data;
  endtask

  task automatic lu(input logic v, input logic [3:0] idx, input logic [15:0] data);
    wb.lu_valid   = v;
    wb.lu_dst_idx = idx;
    wb.lu_data    = data;
  endtask

  task automatic iss(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] d, input logic hd);
    wb.iss_valid    = v;
    wb.iss_src1_idx = s1;
    wb.iss_src2_idx = s2;
    wb.iss_dst_idx  = d;
    wb.iss_has_dst  = hd;
  endtask

  // Every write the DUT makes must match the head of the expected queue.
  always @(negedge clock) begin
    exp_t e;
    if (reset && wb.rf_write) begin
      if (exp_q.size() == 0) begin
        chk("unexp_wr", {28'd0, wb.rf_dst_idx}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_idx",  {28'd0, wb.rf_dst_idx}, {28'd0, e.idx});
        chk("wr_data", {16'd0, wb.rf_dst},     {16'd0, e.data});
      end
    end
  end

  initial begin
    reset = 1'b0;
    alu(0, 0, 0);
    lu(0, 0, 0);
    iss(0, 0, 0, 0, 0);
    repeat (3) cyc();

    // Reset state
    iss(1, 0, 0, 0, 0);
    #1;
    chk("rst_rf_write", wb.rf_write, 0);
    chk("rst_rf_idx",   wb.rf_dst_idx, 0);
    chk("rst_rf_dst",   wb.rf_dst, 0);
    chk("rst_busy",     wb.busy, 0);
    chk("rst_lu_ready", wb.lu_ready, 1);
    chk("rst_stall",    wb.iss_stall, 0);
    iss(0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();

    // First ALU write lands on the port one cycle later
    alu(1, 3, 16'h1234); push(3, 16'h1234);
    cyc();
    alu(0, 0, 0);
    #1;
    chk("alu_lat", wb.rf_write, 1);
    cyc();
    #1;
    chk("alu_one", wb.rf_write, 0);

    // RAW on r5
    iss(1, 0, 0, 5, 1);
    #1;
    chk("raw_iss0", wb.iss_stall, 0);
    cyc();
    iss(1, 5, 0, 0, 0);
    #1;
    chk("raw_busy",   wb.busy[5], 1);
    chk("raw_stall1", wb.iss_stall, 1);
    cyc();
    #1;
    chk("raw_stall2", wb.iss_stall, 1);
    alu(1, 5, 16'hBEEF); push(5, 16'hBEEF);
    #1;
    chk("raw_stall3", wb.iss_stall, 1);
    cyc();
    alu(0, 0, 0);
    #1;
    chk("raw_wr",     wb.rf_write, 1);
    chk("raw_stall4", wb.iss_stall, 1);
    cyc();
    #1;
    chk("raw_clr",    wb.busy[5], 0);
    chk("raw_go",     wb.iss_stall, 0);
    iss(0, 0, 0, 0, 0);
    cyc();

    // ALU / long-unit collision
    alu(1, 2, 16'h0001); push(2, 16'h0001);
    lu(1, 7, 16'h0002);  push(7, 16'h0002);
    #1;
    chk("col_rdy0", wb.lu_ready, 1);
    cyc();
    alu(0, 0, 0); lu(0, 0, 0);
    #1;
    chk("col_idx_n1", wb.rf_dst_idx, 2);
    chk("col_rdy1",   wb.lu_ready, 1);
    cyc();
    #1;
    chk("col_wr_n2",  wb.rf_write, 1);
    chk("col_idx_n2", wb.rf_dst_idx, 7);
    chk("col_rdy2",   wb.lu_ready, 1);
    cyc();

    // Starvation of a held long-unit result
    iss(1, 0, 0, 0, 0);
    lu(1, 9, 16'h0099);
    cyc();
    lu(0, 0, 0);
    alu(1, 10, 16'h00A0); push(10, 16'h00A0);
    #1;
    chk("stv_rdy",    wb.lu_ready, 0);
    chk("stv_stall0", wb.iss_stall, 0);
    cyc();
    alu(1, 11, 16'h00B0); push(11, 16'h00B0);
    #1;
    chk("stv_stall1", wb.iss_stall, 0);
    cyc();
    alu(1, 12, 16'h00C0); push(12, 16'h00C0);
    #1;
    chk("stv_stall2", wb.iss_stall, 0);
    cyc();
    alu(1, 13, 16'h00D0); push(13, 16'h00D0);
    #1;
    chk("stv_stall3", wb.iss_stall, 1);
    cyc();
    alu(0, 0, 0); push(9, 16'h0099);
    #1;
    chk("stv_stall4", wb.iss_stall, 1);
    cyc();
    #1;
    chk("stv_go",     wb.iss_stall, 0);
    chk("stv_wr_idx", wb.rf_dst_idx, 9);
    iss(0, 0, 0, 0, 0);
    cyc();

    // Set/clear race on r4: set wins
    alu(1, 4, 16'h4444); push(4, 16'h4444);
    cyc();
    alu(0, 0, 0);
    iss(1, 0, 0, 4, 1);
    #1;
    chk("race_wr",    wb.rf_write, 1);
    chk("race_stall", wb.iss_stall, 0);
    cyc();
    iss(0, 0, 0, 0, 0);
    #1;
    chk("race_busy",  wb.busy[4], 1);
    alu(1, 4, 16'h0444); push(4, 16'h0444);
    cyc();
    alu(0, 0, 0);
    cyc();
    #1;
    chk("race_clr",   wb.busy[4], 0);

    // Register 0
    alu(1, 0, 16'hFFFF);
    cyc();
    alu(0, 0, 0);
    #1;
    chk("r0_nowr", wb.rf_write, 0);
    chk("r0_keep", wb.rf_dst, 16'h0444);
    iss(1, 0, 0, 0, 1);
    #1;
    chk("r0_stall", wb.iss_stall, 0);
    cyc();
    iss(0, 0, 0, 0, 0);
    #1;
    chk("r0_busy", wb.busy, 0);

    // Reset mid-traffic
    iss(1, 0, 0, 6, 1);
    cyc();
    iss(0, 0, 0, 0, 0);
    alu(1, 1, 16'h0011); push(1, 16'h0011);
    lu(1, 8, 16'h0088);
    cyc();
    alu(1, 14, 16'hEEEE);
    lu(0, 0, 0);
    #1;
    chk("mid_busy6", wb.busy[6], 1);
    chk("mid_wr",    wb.rf_write, 1);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_busy",  wb.busy, 0);
    chk("mrst_wr",    wb.rf_write, 0);
    chk("mrst_rdy",   wb.lu_ready, 1);
    chk("mrst_q",     exp_q.size(), 0);
    alu(0, 0, 0);
    iss(1, 6, 0, 0, 0);
    #1;
    chk("mrst_stall", wb.iss_stall, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    iss(0, 0, 0, 0, 0);
    alu(1, 3, 16'h1234); push(3, 16'h1234);
    cyc();
    alu(0, 0, 0);
    #1;
    chk("post_wr",   wb.rf_write, 1);
    chk("post_data", wb.rf_dst, 16'h1234);
    repeat (3) cyc();
    chk("q_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Writeback stage of the swt16 pipeline, directly upstream of the register file. It merges single-cycle ALU results with results from the long-latency unit (load/multiply), drives the register-file write port, and keeps a per-register busy scoreboard. Issue logic consults the scoreboard and stalls on RAW and WAW hazards. Register 0 is never written and never busy.

## Interface
- WORD_WIDTH, 16, data width
- IDX_WIDTH, 4, register index width; NUM_REGS = 2**IDX_WIDTH
- MAX_WAIT, 3, cycles a held long-unit result may be bypassed by ALU writes before issue is stalled

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- iss_valid  in  1  instruction presented for issue
- iss_src1_idx / iss_src2_idx / iss_dst_idx  in  IDX_WIDTH  operand and destination indices
- iss_has_dst  in  1  instruction writes a register
- iss_stall  out  1  combinational; issue not accepted this cycle
- alu_valid  in  1  ALU result valid; always accepted
- alu_dst_idx  in  IDX_WIDTH; alu_data  in  WORD_WIDTH
- lu_valid  in  1; lu_ready  out  1; lu_dst_idx  in  IDX_WIDTH; lu_data  in  WORD_WIDTH  long-unit valid/ready result channel
- rf_write  out  1; rf_dst_idx  out  IDX_WIDTH; rf_dst  out  WORD_WIDTH  registered write port to register file
- busy  out  NUM_REGS  scoreboard, bit i = register i has a pending write

## Operation
- Hold register: one entry (hold_valid, hold_idx, hold_data). Long-unit transfer when lu_valid && lu_ready; lu_ready = !hold_valid || !alu_valid (a draining hold may be refilled in the same cycle).
- Write select each cycle: alu_valid -> ALU result; else hold_valid -> hold (hold empties unless refilled); else none.
- Selected result with idx 0 is dropped: rf_write = 0, no state change except hold drain.
- Age counter: reset to 0 when hold loads; increments each cycle hold_valid && alu_valid, saturating at MAX_WAIT.
- Scoreboard set: issue accepted (iss_valid && !iss_stall) && iss_has_dst && iss_dst_idx != 0 -> busy[dst] = 1.
- Scoreboard clear: busy[rf_dst_idx] = 0 at the edge after rf_write = 1. Set and clear of the same index in one cycle -> set wins (busy stays 1).
- Result for a non-busy index: still written; busy unchanged.
- iss_stall = iss_valid && (busy[src1] || busy[src2] || (iss_has_dst && busy[dst]) || (age == MAX_WAIT && hold_valid)). busy[0] is constant 0.

## Timing
- Reset values: rf_write 0, rf_dst_idx 0, rf_dst 0, busy all 0, hold_valid 0, age 0; lu_ready therefore 1, iss_stall 0.
- ALU result at edge N -> rf_write high during cycle N+1 -> visible in register file from N+2. Busy clears at the same edge the register file captures the data.
- Long-unit transfer at edge N -> hold valid in cycle N+1 -> rf_write in cycle N+2 at the earliest. Each cycle with alu_valid high adds one cycle of delay.
- Age stall: once age reaches MAX_WAIT, issue stalls. The ALU pipeline then empties and the hold drains. Age stall is combinational and clears as soon as the hold drains.
- Reset mid-operation: hold content and scoreboard are discarded immediately. Results in flight are lost.

## Structure
- Shared package swt16_pkg: WORD_WIDTH, IDX_WIDTH, NUM_REGS constants and a wb_result_t struct {valid, idx, data}, shared with the register file and execute stages.
- Sub-module wb_scoreboard: busy vector with set and clear ports, set-wins priority, and hazard-check outputs. The hold, arbitration and write register stay in writeback_stage.

## Test plan
- Reset: drive reset = 0 mid-traffic -> busy = 0, rf_write = 0, lu_ready = 1. After release, first ALU write (r3, 0x1234) -> rf_write in the next cycle.
- RAW: issue dst = r5, then issue src1 = r5 -> iss_stall = 1 until ALU result r5 = 0xBEEF is written. iss_stall drops the cycle after rf_write.
- Collision: alu_valid (r2, 0x0001) and lu_valid (r7, 0x0002) in the same cycle -> r2 written at N+1, r7 written at N+2, lu_ready = 1 throughout.
- Starvation: hold r9 while alu_valid is held high -> after 3 bypass cycles iss_stall = 1. Once the ALU goes idle, r9 is written and iss_stall = 0.
- Set/clear race: rf_write r4 in the same cycle an issue with dst = r4 is accepted -> busy[4] remains 1.
- Register 0: ALU result idx 0 data 0xFFFF -> rf_write stays 0. Issue dst = r0 -> busy[0] stays 0 and no stall.
